// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, defaults and width helper for the UART TX arbiter
package uart_arb_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // Bits needed to hold values 0 .. value-1 (never less than 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_id
);

  // Scan last+1, last+2, ... with wrap; the first active requester wins,
  // so last itself is checked at the very end and can be re-granted.
  always_comb begin
    int  idx;
    logic found;
    grant_onehot = '0;
    grant_id     = '0;
    found        = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_id          = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between NUM_REQ byte requesters
import uart_arb_pkg::*;

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 200000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(TIMEOUT);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [NUM_REQ-1:0]  cur_oh_q, cur_oh_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  grant_onehot;
  logic [ID_W-1:0]     grant_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req          (req),
    .last         (last_q),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id)
  );

  // State register; last resets to NUM_REQ-1 so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      cur_id_q  <= '0;
      cur_oh_q  <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      cur_id_q  <= cur_id_d;
      cur_oh_q  <= cur_oh_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next state: the counter is 0 in START and reads k in the k-th cycle after
  // tx_start, so expiry at TIMEOUT-1 puts err TIMEOUT cycles after tx_start.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    cur_id_d  = cur_id_q;
    cur_oh_d  = cur_oh_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          tx_data_d = req_data[int'(grant_id)*DATA_W +: DATA_W];
          cur_id_d  = grant_id;
          cur_oh_d  = grant_onehot;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = CNT_W'(1);
        state_d = BUSY;
      end
      BUSY: begin
        if (tx_done) begin
          done_d  = cur_oh_q;
          last_d  = cur_id_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = cur_oh_q;
          last_d  = cur_id_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_start = (state_q == START);
  assign ack      = tx_start ? cur_oh_q : '0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_done;

  logic [3:0]  ack, done;
  logic        err, busy, tx_start;
  logic [7:0]  tx_data;

  logic [3:0]  t_ack, t_done;
  logic        t_err, t_busy, t_tx_start;
  logic [7:0]  t_tx_data;

  int n_cmp;
  int n_err;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(200000)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .err(err), .busy(busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(t_ack), .done(t_done), .err(t_err), .busy(t_busy),
    .tx_start(t_tx_start), .tx_data(t_tx_data), .tx_done(tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = 4'b0000;
    tx_done = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; req_data = 32'h44332211; tx_done = 1'b1;
    repeat (2) tick();
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
    n_cmp++; if ({err, busy, tx_start} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {err, busy, tx_start}); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if ({t_err, t_busy, t_tx_start, t_ack, t_done} !== 11'd0) begin n_err++; $display("FAIL reset_t_outputs: got %b want 0", {t_err, t_busy, t_tx_start, t_ack, t_done}); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; req_data = 32'h000000A5;
    tick();
    n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_tx_start: got %b want 1", tx_start); end
    n_cmp++; if (ack !== 4'b0001) begin n_err++; $display("FAIL single_ack: got %b want 0001", ack); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    req = 4'b0000;
    tick();
    n_cmp++; if ({tx_start, ack} !== 5'b00000) begin n_err++; $display("FAIL single_pulse_width: got %b want 00000", {tx_start, ack}); end
    repeat (49) tick();
    tx_done = 1'b1;
    n_cmp++; if ({done, busy} !== 5'b00001) begin n_err++; $display("FAIL single_pre_done: got %b want 00001", {done, busy}); end
    tick();
    tx_done = 1'b0;
    n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL single_done: got %b want 0001", done); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", err); end
    tick();
    n_cmp++; if ({done, busy} !== 5'b00000) begin n_err++; $display("FAIL single_after_done: got %b want 00000", {done, busy}); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold: got %h want a5", tx_data); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_data [5];
    logic [3:0] exp_oh [5];
    exp_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_oh   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111; req_data = 32'h13121110;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({tx_start, ack} !== {1'b1, exp_oh[k]}) begin n_err++; $display("FAIL fair_grant_%0d: got %b want %b", k, {tx_start, ack}, {1'b1, exp_oh[k]}); end
      n_cmp++; if (tx_data !== exp_data[k]) begin n_err++; $display("FAIL fair_data_%0d: got %h want %h", k, tx_data, exp_data[k]); end
      repeat (3) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_cmp++; if ({done, tx_start} !== {exp_oh[k], 1'b0}) begin n_err++; $display("FAIL fair_done_%0d: got %b want %b", k, {done, tx_start}, {exp_oh[k], 1'b0}); end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b0100; req_data = 32'h00220000;
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL rot_first: got %b want 0100", ack); end
    req = 4'b0000;
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_cmp++; if (done !== 4'b0100) begin n_err++; $display("FAIL rot_done2: got %b want 0100", done); end
    req = 4'b0101; req_data = 32'h00320030;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_err++; $display("FAIL rot_wrap_to_0: got %b want 0001", ack); end
    n_cmp++; if (tx_data !== 8'h30) begin n_err++; $display("FAIL rot_data0: got %h want 30", tx_data); end
    req = 4'b0100;
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL rot_done0: got %b want 0001", done); end
    tick();
    n_cmp++; if ({ack, tx_data} !== {4'b0100, 8'h32}) begin n_err++; $display("FAIL rot_then_2: got %h want 432", {ack, tx_data}); end
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b1000; req_data = 32'h77000000;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if ({ack, tx_data} !== {4'b1000, 8'h77}) begin n_err++; $display("FAIL b2b_grant_%0d: got %h want 877", k, {ack, tx_data}); end
      repeat (2) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_cmp++; if (done !== 4'b1000) begin n_err++; $display("FAIL b2b_done_%0d: got %b want 1000", k, done); end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010; req_data = 32'h00005A00;
    tick();
    n_cmp++; if ({t_tx_start, t_ack, t_tx_data} !== {1'b1, 4'b0010, 8'h5A}) begin n_err++; $display("FAIL to_start: got %h want 125a", {t_tx_start, t_ack, t_tx_data}); end
    req = 4'b0000;
    repeat (15) tick();
    n_cmp++; if ({t_err, t_busy, t_done} !== 6'b010000) begin n_err++; $display("FAIL to_before_expiry: got %b want 010000", {t_err, t_busy, t_done}); end
    tick();
    n_cmp++; if ({t_err, t_busy, t_done} !== 6'b100010) begin n_err++; $display("FAIL to_expiry: got %b want 100010", {t_err, t_busy, t_done}); end
    tick();
    n_cmp++; if ({t_err, t_done} !== 5'b00000) begin n_err++; $display("FAIL to_pulse_width: got %b want 00000", {t_err, t_done}); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    n_cmp++; if ({t_err, t_busy, t_tx_start, t_done} !== 7'd0) begin n_err++; $display("FAIL to_late_tx_done: got %b want 0000000", {t_err, t_busy, t_tx_start, t_done}); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req = 4'b0010; req_data = 32'h0000BB00;
    tick();
    n_cmp++; if (ack !== 4'b0010) begin n_err++; $display("FAIL rmb_grant1: got %b want 0010", ack); end
    req = 4'b0000;
    repeat (10) tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({busy, tx_start, err, ack, done} !== 11'd0) begin n_err++; $display("FAIL rmb_async_outputs: got %b want 0", {busy, tx_start, err, ack, done}); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rmb_tx_data: got %h want 00", tx_data); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if ({done, err} !== 5'b00000) begin n_err++; $display("FAIL rmb_no_done: got %b want 00000", {done, err}); end
    req = 4'b1111; req_data = 32'h43424140;
    tick();
    n_cmp++; if ({ack, tx_data} !== {4'b0001, 8'h40}) begin n_err++; $display("FAIL rmb_next_grant: got %h want 140", {ack, tx_data}); end
    req = 4'b0000;
  endtask

  task automatic test_corner();
    do_reset();
    req = 4'b0001; req_data = 32'h00000066;
    tick();
    req = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_cmp++; if ({t_done, t_busy} !== 5'b00001) begin n_err++; $display("FAIL corner_done_in_start: got %b want 00001", {t_done, t_busy}); end
    repeat (14) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_cmp++; if ({t_done, t_err} !== 5'b00010) begin n_err++; $display("FAIL corner_tie: got %b want 00010", {t_done, t_err}); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_cmp++; if ({t_done, t_err, t_busy, t_tx_start} !== 7'd0) begin n_err++; $display("FAIL corner_idle_tx_done: got %b want 0000000", {t_done, t_err, t_busy, t_tx_start}); end
    n_cmp++; if (t_tx_data !== 8'h66) begin n_err++; $display("FAIL corner_data_hold: got %h want 66", t_tx_data); end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    tx_done  = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_rotation();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one UART transmitter, range 2..8.
REQ-002 Parameter DATA_W, default 8, is the byte width.
REQ-003 Parameter TIMEOUT, default 200000, is the maximum number of clk cycles allowed from tx_start to tx_done.
REQ-004 clk  input  1  is the single clock; all logic is rising-edge.
REQ-005 reset  input  1  is the asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  has one bit per requester; a requester holds its bit high until it receives ack.
REQ-007 req_data  input  NUM_REQ*DATA_W  carries the bytes; requester i drives bits [i*DATA_W +: DATA_W], held stable while req[i]=1.
REQ-008 ack  output  NUM_REQ  is a one-hot, 1-cycle pulse meaning the byte from requester i is captured.
REQ-009 done  output  NUM_REQ  is a one-hot, 1-cycle pulse meaning requester i's byte finished transmission.
REQ-010 err  output  1  is a 1-cycle pulse on transmitter timeout.
REQ-011 busy  output  1  is high whenever state is not IDLE.
REQ-012 tx_start  output  1  is the start pulse to the transmitter.
REQ-013 tx_data  output  DATA_W  is the byte to the transmitter, held stable from tx_start until return to IDLE.
REQ-014 tx_done  input  1  is the transmitter's tx_done_tick.

Function
REQ-015 The FSM SHALL have three states: IDLE, START and BUSY.
REQ-016 In IDLE with req≠0, on the clk edge the arbiter SHALL:
- pick winner w by round-robin, searching from (last+1) mod NUM_REQ upward with wrap;
- latch req_data[w] into tx_data and w into cur_id;
- move to START.
REQ-017 In IDLE with req=0, the state SHALL remain IDLE and tx_data SHALL hold its value.
REQ-018 START SHALL last exactly one cycle, with tx_start=1 and ack[cur_id]=1; the next state is BUSY.
REQ-019 Latency SHALL be 1 cycle: req sampled at edge N gives tx_start/ack during cycle N+1.
REQ-020 In BUSY, tx_done=1 SHALL pulse done[cur_id] for the next cycle, set last=cur_id and return to IDLE.
REQ-021 In BUSY, a timeout counter SHALL count cycles from entry.
REQ-022 If the timeout count reaches TIMEOUT-1 without tx_done, err and done[cur_id] SHALL pulse for one cycle, last=cur_id, and the state returns to IDLE.
REQ-023 If tx_done and timeout expiry occur on the same cycle, tx_done wins and err SHALL stay 0.
REQ-024 tx_done arriving in IDLE or START SHALL be ignored.
REQ-025 Requests arriving during START/BUSY SHALL wait; arbitration happens on the first IDLE edge, so the minimum gap from done to the next tx_start is 1 idle cycle.
REQ-026 A req bit dropped before ack is legal; that requester SHALL simply not be granted.
REQ-027 If only one requester is active, it SHALL be re-granted every transaction (no starvation of self).
REQ-028 With all requesters continuously active, grants SHALL rotate 0,1,...,NUM_REQ-1,0,...
REQ-029 ack, done, tx_start and err SHALL never be high for more than one consecutive cycle per transaction.

Reset
REQ-030 While reset=1, asynchronously:
- state=IDLE;
- tx_start=0, ack=0, done=0, err=0, busy=0;
- tx_data=0, cur_id=0;
- timeout counter=0;
- last=NUM_REQ-1, so requester 0 has first priority.
REQ-031 Reset during START or BUSY SHALL abandon the transaction with no done or err pulse.

Structure
REQ-032 Shared package uart_arb_pkg SHALL hold:
- the state enum (IDLE, START, BUSY);
- the default DATA_W;
- the timeout counter width function clog2(TIMEOUT).
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter.
- Inputs: req, last.
- Outputs: grant_onehot, grant_id.
- Purely combinational.
REQ-034 The FSM, data latch and timeout counter SHALL reside in uart_tx_arbiter.

Verification
REQ-035 Single request: after reset, req=4'b0001 with data 0xA5 ->
- ack[0] and tx_start in the same cycle, one cycle after req sampled;
- tx_data=0xA5;
- tx_done 50 cycles later -> done[0] next cycle;
- busy low one cycle after that.
REQ-036 Fairness: req=4'b1111 held, data 0x10..0x13 -> tx_start order is 0x10,0x11,0x12,0x13,0x10, each following the previous tx_done.
REQ-037 Rotation pointer: grant 2 completes; then req=4'b0101 -> requester 0 is granted first (search 3,0); next grant is requester 2.
REQ-038 Timeout: TIMEOUT=16, no tx_done ->
- err and done[cur_id] pulse 16 cycles after tx_start;
- state returns to IDLE;
- a tx_done arriving afterwards is ignored.
REQ-039 Reset mid-BUSY: reset asserted 10 cycles after tx_start ->
- all outputs 0 immediately;
- no done pulse;
- next grant goes to requester 0.
REQ-040 Corner events:
- tx_done on the timeout-expiry cycle -> done only, err=0;
- tx_done asserted while IDLE -> no outputs change.
